// File: rtl/uart_pkg.sv
// Shared constants for the Wishbone UART: register offsets, STATUS/CTRL
// bit positions and the 2-bit TX/RX state encodings.
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_TXFULL  = 0;
    localparam int ST_TXEMPTY = 1;
    localparam int ST_RXV     = 2;
    localparam int ST_RXOVR   = 3;
    localparam int ST_FERR    = 4;
    localparam int ST_TXOVF   = 5;
    localparam int ST_TXBUSY  = 6;

    localparam int CT_TXEN = 0;
    localparam int CT_RXEN = 1;
    localparam int CT_RXIE = 2;
    localparam int CT_TXIE = 3;

    typedef enum logic [1:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

endpackage

// File: rtl/wb_uart_if.sv
// Wishbone B4 classic bus bundle between a master and the UART slave.
// Signals: adr/dat_i/sel/we/cyc/stb from master, ack/dat_o from slave.
interface wb_uart_if;

    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_ack_o, wb_dat_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_ack_o, wb_dat_o
    );

endinterface

// File: rtl/uart_fifo.sv
// First-word-fall-through synchronous FIFO (dout valid while !empty).
// Ports: clk, rst (sync, high), push/din, pop/dout, full, empty.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;
    logic             w_pop;
    logic             w_push;

    assign empty  = (r_cnt == '0);
    assign full   = (r_cnt == FULL_CNT);
    assign dout   = r_mem[r_rp];
    // a pop on a full FIFO frees the slot the simultaneous push uses
    assign w_pop  = pop & !empty;
    assign w_push = push & (!full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/wb_uart.sv
// Wishbone classic slave 8N1 UART: TX FIFO, single RX holding register,
// baud divisor, level irq. Ports: wb_clk_i, wb_rst_i, wb (slave), txd, rxd, irq.
module wb_uart
    import uart_pkg::*;
#(
    parameter int          TX_DEPTH    = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    wb_uart_if.slave   wb,
    output logic       txd,
    input  logic       rxd,
    output logic       irq
);

    logic        r_ack;
    logic [31:0] r_dat;
    logic [15:0] r_div;
    logic [3:0]  r_ctrl;
    logic [7:0]  r_rx_byte;
    logic        r_rxv, r_rxovr, r_ferr, r_txovf, r_irq, r_txd;
    logic        r_rx_s1, r_rx_s2, r_rx_s3;

    tx_state_t   r_tx_state, w_tx_next;
    logic [15:0] r_tx_cnt;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_sh;

    rx_state_t   r_rx_state, w_rx_next;
    logic [15:0] r_rx_cnt;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_sh;

    logic        w_commit, w_wr, w_rd_data, w_push, w_full, w_empty;
    logic        w_tx_pop, w_txd_nxt, w_tx_tick, w_busy;
    logic        w_rx_start, w_rx_tick, w_rx_done;
    logic [15:0] w_half_ld;
    logic [1:0]  w_adr;
    logic [7:0]  w_fifo_dout, w_status;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_unused  = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1:0],
                         wb.wb_dat_i[31:16], wb.wb_sel_i[3:1]};
    assign w_adr     = wb.wb_adr_i[3:2];
    assign w_commit  = wb.wb_cyc_i & wb.wb_stb_i & !r_ack;
    assign w_wr      = w_commit & wb.wb_we_i & wb.wb_sel_i[0];
    assign w_rd_data = w_commit & !wb.wb_we_i & (w_adr == REG_DATA);
    assign w_push    = w_wr & (w_adr == REG_DATA);
    assign w_busy    = (r_tx_state != TX_IDLE);
    assign w_tx_tick = (r_tx_cnt == '0);
    assign w_rx_tick = (r_rx_cnt == '0);
    // ((DIV+1)>>1)-1 cycles to reach mid start bit; DIV=0 gives one cycle
    assign w_half_ld = (r_div == '0) ? '0 : (r_div - 16'd1) >> 1;

    assign wb.wb_ack_o = r_ack;
    assign wb.wb_dat_o = r_dat;
    assign txd = r_txd;
    assign irq = r_irq;

    uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_fifo (
        .clk(wb_clk_i), .rst(wb_rst_i),
        .push(w_push), .pop(w_tx_pop), .din(wb.wb_dat_i[7:0]),
        .dout(w_fifo_dout), .full(w_full), .empty(w_empty)
    );

    always_comb begin
        w_status = '0;
        w_status[ST_TXFULL]  = w_full;
        w_status[ST_TXEMPTY] = w_empty;
        w_status[ST_RXV]     = r_rxv;
        w_status[ST_RXOVR]   = r_rxovr;
        w_status[ST_FERR]    = r_ferr;
        w_status[ST_TXOVF]   = r_txovf;
        w_status[ST_TXBUSY]  = w_busy;
        w_rdata = '0;
        case (w_adr)
            REG_DATA:   w_rdata[7:0]  = r_rx_byte;
            REG_STATUS: w_rdata[7:0]  = w_status;
            REG_DIV:    w_rdata[15:0] = r_div;
            default:    w_rdata[3:0]  = r_ctrl;
        endcase
    end

    // ---------------- TX FSM ----------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_tx_state <= TX_IDLE;
        else          r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        unique case (r_tx_state)
            TX_IDLE:  if (w_tx_pop) w_tx_next = TX_START;
            TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
            TX_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = TX_STOP;
            TX_STOP:  if (w_tx_tick) w_tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        w_tx_pop  = 1'b0;
        w_txd_nxt = 1'b1;
        case (r_tx_state)
            TX_IDLE:  w_tx_pop  = r_ctrl[CT_TXEN] & !w_empty;
            TX_START: w_txd_nxt = 1'b0;
            TX_DATA:  w_txd_nxt = r_tx_sh[0];
            default:  w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_txd    <= 1'b1;
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            r_tx_sh  <= '0;
        end else begin
            r_txd <= w_txd_nxt;
            if (w_tx_pop) begin
                r_tx_cnt <= r_div;
                r_tx_bit <= '0;
                r_tx_sh  <= w_fifo_dout;
            end else if (w_busy) begin
                if (w_tx_tick) begin
                    r_tx_cnt <= r_div;
                    if (r_tx_state == TX_DATA) begin
                        r_tx_sh  <= r_tx_sh >> 1;
                        r_tx_bit <= r_tx_bit + 3'd1;
                    end
                end else begin
                    r_tx_cnt <= r_tx_cnt - 16'd1;
                end
            end
        end
    end

    // ---------------- RX FSM ----------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_s1    <= rxd;
            r_rx_s2    <= r_rx_s1;
            r_rx_s3    <= r_rx_s2;
            r_rx_state <= w_rx_next;
        end
    end

    always_comb begin
        w_rx_next = r_rx_state;
        unique case (r_rx_state)
            RX_IDLE:  if (w_rx_start) w_rx_next = RX_START;
            RX_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        w_rx_start = (r_rx_state == RX_IDLE) & r_ctrl[CT_RXEN]
                   & r_rx_s3 & !r_rx_s2;
        w_rx_done  = (r_rx_state == RX_STOP) & w_rx_tick;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            r_rx_sh  <= '0;
        end else if (w_rx_start) begin
            r_rx_cnt <= w_half_ld;
            r_rx_bit <= '0;
        end else if (r_rx_state != RX_IDLE) begin
            if (w_rx_tick) begin
                r_rx_cnt <= r_div;
                if (r_rx_state == RX_DATA) begin
                    r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                    r_rx_bit <= r_rx_bit + 3'd1;
                end
            end else begin
                r_rx_cnt <= r_rx_cnt - 16'd1;
            end
        end
    end

    // ---------------- registers / bus ----------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack     <= 1'b0;
            r_dat     <= '0;
            r_div     <= DEFAULT_DIV;
            r_ctrl    <= '0;
            r_rx_byte <= '0;
            r_rxv     <= 1'b0;
            r_rxovr   <= 1'b0;
            r_ferr    <= 1'b0;
            r_txovf   <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_ack <= wb.wb_cyc_i & wb.wb_stb_i & !r_ack;
            r_dat <= (w_commit & !wb.wb_we_i) ? w_rdata : '0;
            if (w_wr && w_adr == REG_DIV)  r_div  <= wb.wb_dat_i[15:0];
            if (w_wr && w_adr == REG_CTRL) r_ctrl <= wb.wb_dat_i[3:0];
            if (w_wr && w_adr == REG_STATUS) begin
                if (wb.wb_dat_i[ST_RXOVR]) r_rxovr <= 1'b0;
                if (wb.wb_dat_i[ST_FERR])  r_ferr  <= 1'b0;
                if (wb.wb_dat_i[ST_TXOVF]) r_txovf <= 1'b0;
            end
            if (w_push && w_full && !w_tx_pop) r_txovf <= 1'b1;
            if (w_rd_data) r_rxv <= 1'b0;
            // a byte landing on the same edge as the clearing read wins
            if (w_rx_done) begin
                if (!r_rx_s2) r_ferr <= 1'b1;
                if (r_rxv && !w_rd_data) begin
                    r_rxovr <= 1'b1;
                end else begin
                    r_rx_byte <= r_rx_sh;
                    r_rxv     <= 1'b1;
                end
            end
            r_irq <= (r_rxv & r_ctrl[CT_RXIE])
                   | (w_empty & !w_busy & r_ctrl[CT_TXIE]);
        end
    end

endmodule

// File: tb/tb_wb_uart.sv
// Self-checking bench for wb_uart: bus register access, TX waveform and
// FIFO overflow, RX delivery/overrun/glitch/framing, irq, reset mid-frame.
module tb_wb_uart;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic txd;
    logic rxd = 1'b1;
    logic irq;

    wb_uart_if bus();

    wb_uart dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus),
        .txd(txd), .rxd(rxd), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int tb_div = 433;

    // RX holding-register model
    bit       m_rxv, m_rxovr, m_ferr;
    bit [7:0] m_byte;

    // serial TX decoder
    bit       mon_en = 1'b0;
    bit       mon_prev = 1'b1;
    int       mon_bad = 0;
    bit [7:0] mon_q[$];

    always begin : tx_mon
        bit [7:0] b;
        int per;
        @(negedge clk);
        if (mon_en && mon_prev && !txd) begin
            per = tb_div + 1;
            repeat (per / 2) @(negedge clk);
            if (txd) mon_bad++;
            for (int i = 0; i < 8; i++) begin
                repeat (per) @(negedge clk);
                b[i] = txd;
            end
            repeat (per) @(negedge clk);
            if (!txd) mon_bad++;
            mon_q.push_back(b);
        end
        mon_prev = txd;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wb_xfer(input logic we, input logic [1:0] a,
                           input logic [31:0] d, input logic [3:0] sel,
                           output logic [31:0] q);
        bit got = 1'b0;
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = {28'h0, a, 2'b00};
        bus.wb_dat_i = d;
        bus.wb_sel_i = sel;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = bus.wb_ack_o;
        end
        q = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL wb_ack_timeout: adr %0d got no ack, need ack", a);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] q;
        wb_xfer(1'b1, a, d, 4'h1, q);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] q);
        wb_xfer(1'b0, a, 32'h0, 4'hF, q);
    endtask

    function automatic logic [31:0] exp_status();
        return {27'h0, m_ferr, m_rxovr, m_rxv, 1'b1, 1'b0};
    endfunction

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        int per = tb_div + 1;
        @(negedge clk);
        rxd = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (per) @(negedge clk);
        end
        rxd = stop;
        repeat (per) @(negedge clk);
        rxd = 1'b1;
        repeat (per + 6) @(negedge clk);
        if (!stop) m_ferr = 1'b1;
        if (m_rxv) begin
            m_rxovr = 1'b1;
        end else begin
            m_byte = b;
            m_rxv = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] q;
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
        bus.wb_adr_i = 0; bus.wb_dat_i = 0; bus.wb_sel_i = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (txd !== 1'b1) begin
            n_fail++; $display("FAIL reset_txd: got %b need 1", txd);
        end
        n_chk++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq: got %b need 0", irq);
        end
        n_chk++;
        if (bus.wb_ack_o !== 1'b0 || bus.wb_dat_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_bus: ack %b dat %h need 0/0",
                     bus.wb_ack_o, bus.wb_dat_o);
        end
        rst = 1'b0;
        rd(2'd1, q);
        n_chk++;
        if (q !== 32'h02) begin
            n_fail++; $display("FAIL reset_status: got %h need 02", q);
        end
        rd(2'd2, q);
        n_chk++;
        if (q !== 32'd433) begin
            n_fail++; $display("FAIL reset_div: got %0d need 433", q);
        end
        rd(2'd3, q);
        n_chk++;
        if (q !== 32'h0) begin
            n_fail++; $display("FAIL reset_ctrl: got %h need 0", q);
        end
    endtask

    task automatic test_sel_gate();
        logic [31:0] q;
        logic [31:0] d;
        wb_xfer(1'b1, 2'd2, 32'd5, 4'h0, q);
        rd(2'd2, q);
        n_chk++;
        if (q !== 32'd433) begin
            n_fail++; $display("FAIL sel0_ignored: got %0d need 433", q);
        end
        d = {$urandom, $urandom_range(0, 15)};
        wr(2'd2, d);
        rd(2'd2, q);
        n_chk++;
        if (q !== {16'h0, d[15:0]}) begin
            n_fail++; $display("FAIL div_rw: got %h need %h", q, d[15:0]);
        end
    endtask

    task automatic test_tx_frame();
        logic [31:0] q;
        logic [7:0]  b = 8'h55;
        bit          exp[$];
        tb_div = 3;
        wr(2'd2, 32'd3);
        wr(2'd3, 32'h1);
        exp.push_back(1'b1);
        repeat (4) exp.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (4) exp.push_back(b[i]);
        repeat (5) exp.push_back(1'b1);
        wr(2'd0, {24'h0, b});
        fork
            begin
                for (int k = 0; k < exp.size(); k++) begin
                    @(negedge clk);
                    n_chk++;
                    if (txd !== exp[k]) begin
                        n_fail++;
                        $display("FAIL tx_wave[%0d]: got %b need %b",
                                 k, txd, exp[k]);
                    end
                end
            end
            begin
                logic [31:0] s;
                repeat (10) @(negedge clk);
                rd(2'd1, s);
                n_chk++;
                if (s !== 32'h42) begin
                    n_fail++; $display("FAIL tx_busy: got %h need 42", s);
                end
            end
        join
        repeat (4) @(negedge clk);
        rd(2'd1, q);
        n_chk++;
        if (q !== 32'h02) begin
            n_fail++; $display("FAIL tx_done_status: got %h need 02", q);
        end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] q;
        logic [7:0]  bytes[9];
        wr(2'd3, 32'h0);
        for (int i = 0; i < 9; i++) begin
            bytes[i] = 8'($urandom);
            wr(2'd0, {24'h0, bytes[i]});
        end
        rd(2'd1, q);
        n_chk++;
        if (q !== 32'h21) begin
            n_fail++; $display("FAIL ovf_status: got %h need 21", q);
        end
        mon_q.delete();
        mon_bad = 0;
        mon_en = 1'b1;
        wr(2'd3, 32'h1);
        for (int c = 0; c < 1000 && mon_q.size() < 8; c++) @(negedge clk);
        repeat (100) @(negedge clk);
        mon_en = 1'b0;
        n_chk++;
        if (mon_q.size() != 8 || mon_bad != 0) begin
            n_fail++;
            $display("FAIL ovf_frames: got %0d frames (%0d bad) need 8",
                     mon_q.size(), mon_bad);
        end
        for (int i = 0; i < 8 && i < mon_q.size(); i++) begin
            n_chk++;
            if (mon_q[i] !== bytes[i]) begin
                n_fail++;
                $display("FAIL ovf_byte[%0d]: got %h need %h",
                         i, mon_q[i], bytes[i]);
            end
        end
        rd(2'd1, q);
        n_chk++;
        if (q !== 32'h22) begin
            n_fail++; $display("FAIL ovf_sticky: got %h need 22", q);
        end
        wr(2'd1, 32'h20);
        rd(2'd1, q);
        n_chk++;
        if (q !== 32'h02) begin
            n_fail++; $display("FAIL ovf_w1c: got %h need 02", q);
        end
        wr(2'd3, 32'h0);
    endtask

    task automatic check_rx(input string tag);
        logic [31:0] q;
        rd(2'd1, q);
        n_chk++;
        if (q !== exp_status()) begin
            n_fail++;
            $display("FAIL %s_status: got %h need %h", tag, q, exp_status());
        end
    endtask

    task automatic read_rx(input string tag);
        logic [31:0] q;
        rd(2'd0, q);
        n_chk++;
        if (q !== {24'h0, m_byte}) begin
            n_fail++;
            $display("FAIL %s_data: got %h need %h", tag, q, m_byte);
        end
        m_rxv = 1'b0;
    endtask

    task automatic test_rx();
        logic [7:0] b1, b2;
        tb_div = 3;
        wr(2'd2, 32'd3);
        wr(2'd3, 32'h2);
        rx_frame(8'hA3, 1'b1);
        check_rx("rx_a3");
        read_rx("rx_a3");
        check_rx("rx_cleared");
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        rx_frame(b1, 1'b1);
        rx_frame(b2, 1'b1);
        check_rx("rx_overrun");
        read_rx("rx_first");
        wr(2'd1, 32'h08);
        m_rxovr = 1'b0;
        check_rx("rx_ovr_w1c");
    endtask

    task automatic test_rx_glitch_ferr();
        tb_div = 7;
        wr(2'd2, 32'd7);
        @(negedge clk);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        check_rx("rx_glitch");
        rx_frame(8'($urandom), 1'b0);
        check_rx("rx_ferr");
        read_rx("rx_ferr");
        wr(2'd1, 32'h10);
        m_ferr = 1'b0;
        check_rx("rx_ferr_w1c");
    endtask

    task automatic test_irq();
        logic [3:0] ctl[2] = '{4'h6, 4'hE};
        bit         e;
        tb_div = 3;
        wr(2'd2, 32'd3);
        for (int k = 0; k < 2; k++) begin
            wr(2'd3, {28'h0, ctl[k]});
            repeat (3) @(negedge clk);
            e = ctl[k][3];
            n_chk++;
            if (irq !== e) begin
                n_fail++; $display("FAIL irq_idle[%0d]: got %b need %b", k, irq, e);
            end
            rx_frame(8'($urandom), 1'b1);
            n_chk++;
            if (irq !== 1'b1) begin
                n_fail++; $display("FAIL irq_rx[%0d]: got %b need 1", k, irq);
            end
            read_rx("irq");
            repeat (3) @(negedge clk);
            e = (m_rxv & ctl[k][2]) | ctl[k][3];
            n_chk++;
            if (irq !== e) begin
                n_fail++; $display("FAIL irq_read[%0d]: got %b need %b", k, irq, e);
            end
        end
        wr(2'd3, 32'h0);
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        @(negedge clk);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 32'h8;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.wb_ack_o) begin
                acks++;
                n_chk++;
                if (bus.wb_dat_o !== 32'(tb_div)) begin
                    n_fail++;
                    $display("FAIL b2b_data: got %h need %h", bus.wb_dat_o, tb_div);
                end
            end
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        n_chk++;
        if (acks != 4) begin
            n_fail++; $display("FAIL b2b_acks: got %0d need 4", acks);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] q;
        tb_div = 7;
        wr(2'd2, 32'd7);
        wr(2'd3, 32'h1);
        wr(2'd0, 32'h00);
        repeat (20) @(negedge clk);
        n_chk++;
        if (txd !== 1'b0) begin
            n_fail++; $display("FAIL midframe_txd: got %b need 0", txd);
        end
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (txd !== 1'b1) begin
            n_fail++; $display("FAIL rst_txd: got %b need 1", txd);
        end
        rst = 1'b0;
        tb_div = 433;
        rd(2'd1, q);
        n_chk++;
        if (q !== 32'h02) begin
            n_fail++; $display("FAIL rst_status: got %h need 02", q);
        end
        rd(2'd2, q);
        n_chk++;
        if (q !== 32'd433) begin
            n_fail++; $display("FAIL rst_div: got %0d need 433", q);
        end
        n_chk++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL rst_irq: got %b need 0", irq);
        end
    endtask

    initial begin
        test_reset();
        test_sel_gate();
        test_tx_frame();
        test_tx_overflow();
        test_rx();
        test_rx_glitch_ferr();
        test_irq();
        test_back_to_back();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
